// File: rtl/l1_cache_pkg.sv
// Shared geometry, address split and controller state encoding for the L1 data cache.
package l1_cache_pkg;
  localparam int NUM_SETS       = 128;
  localparam int WAYS           = 4;
  localparam int WORDS_PER_LINE = 4;
  localparam int OFF_W          = 2;
  localparam int WORD_W         = $clog2(WORDS_PER_LINE);
  localparam int IDX_W          = $clog2(NUM_SETS);
  localparam int WAY_W          = $clog2(WAYS);
  localparam int TAG_W          = 32 - IDX_W - WORD_W - OFF_W;

  localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(WORDS_PER_LINE - 1);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] word;
  } addr_t;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WRITEBACK, REFILL_REQ, REFILL_WAIT, RESPOND
  } state_e;

  // Takes the word address (byte offset already stripped).
  function automatic addr_t split_addr(input logic [31-OFF_W:0] wa);
    return addr_t'(wa);
  endfunction
endpackage

// File: rtl/l1_data_array.sv
// Line data storage: one synchronous write port, one combinational read port, no reset.
module l1_data_array
  import l1_cache_pkg::*;
#(
  parameter int SETS       = NUM_SETS,
  parameter int NWAYS      = WAYS,
  parameter int LINE_WORDS = WORDS_PER_LINE
) (
  input  logic                          clk,
  input  logic                          we_i,
  input  logic [$clog2(SETS)-1:0]       wset_i,
  input  logic [$clog2(NWAYS)-1:0]      wway_i,
  input  logic [$clog2(LINE_WORDS)-1:0] wword_i,
  input  logic [31:0]                   wdata_i,
  input  logic [$clog2(SETS)-1:0]       rset_i,
  input  logic [$clog2(NWAYS)-1:0]      rway_i,
  input  logic [$clog2(LINE_WORDS)-1:0] rword_i,
  output logic [31:0]                   rdata_o
);
  logic [31:0] mem_q [SETS*NWAYS*LINE_WORDS];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[{wset_i, wway_i, wword_i}] <= wdata_i;
  end

  assign rdata_o = mem_q[{rset_i, rway_i, rword_i}];
endmodule

// File: rtl/l1_cache_controller.sv
// 4-way write-back / write-allocate L1 data cache controller; one CPU request in flight.
module l1_cache_controller
  import l1_cache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req_valid,
  output logic        cpu_req_ready,
  input  logic [31:0] cpu_req_addr,
  input  logic        cpu_req_we,
  input  logic [31:0] cpu_req_wdata,
  output logic        cpu_resp_valid,
  output logic [31:0] cpu_resp_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_we,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  state_e state_q, state_d;
  addr_t  addr_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [WAY_W-1:0]  way_q, way_d;
  logic              by_ptr_q, by_ptr_d;
  logic [WORD_W-1:0] beat_q, beat_d;
  logic [31:0] hit_cnt_q, miss_cnt_q;

  logic [TAG_W-1:0]               tag_q [NUM_SETS][WAYS];
  logic [NUM_SETS-1:0][WAYS-1:0]  valid_q, dirty_q;
  logic [NUM_SETS-1:0][WAY_W-1:0] ptr_q;

  logic [IDX_W-1:0]  idx;
  logic              hit, inv_found, refill_done;
  logic [WAY_W-1:0]  hit_way, inv_way, victim;

  logic              arr_we;
  logic [WAY_W-1:0]  arr_way;
  logic [WORD_W-1:0] arr_word, rd_word;
  logic [31:0]       arr_wdata, rd_data;

  logic unused_off;
  assign unused_off = ^cpu_req_addr[OFF_W-1:0];

  assign idx = addr_q.idx;

  // Descending scan so the lowest-index match / invalid way wins.
  always_comb begin
    hit = 1'b0; hit_way = '0; inv_found = 1'b0; inv_way = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (valid_q[idx][w] && tag_q[idx][w] == addr_q.tag) begin
        hit = 1'b1; hit_way = WAY_W'(w);
      end
      if (!valid_q[idx][w]) begin
        inv_found = 1'b1; inv_way = WAY_W'(w);
      end
    end
  end

  assign victim      = inv_found ? inv_way : ptr_q[idx];
  assign refill_done = (state_q == REFILL_WAIT) && mem_resp_valid && (beat_q == LAST_BEAT);

  always_comb begin
    state_d = state_q; way_d = way_q; by_ptr_d = by_ptr_q; beat_d = beat_q;
    cpu_req_ready = 1'b0; cpu_resp_valid = 1'b0; cpu_resp_rdata = '0;
    mem_req_valid = 1'b0; mem_req_we = 1'b0; mem_req_addr = '0; mem_req_wdata = '0;
    arr_we = 1'b0; arr_way = way_q; arr_word = addr_q.word; arr_wdata = wdata_q;
    rd_word = addr_q.word;
    case (state_q)
      IDLE: begin
        cpu_req_ready = 1'b1;
        if (cpu_req_valid) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          way_d   = hit_way;
          arr_way = hit_way;
          arr_we  = we_q;
          state_d = RESPOND;
        end else begin
          way_d    = victim;
          by_ptr_d = !inv_found;
          beat_d   = '0;
          state_d  = (valid_q[idx][victim] && dirty_q[idx][victim]) ? WRITEBACK : REFILL_REQ;
        end
      end
      WRITEBACK: begin
        rd_word       = beat_q;
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = {tag_q[idx][way_q], idx, beat_q, {OFF_W{1'b0}}};
        mem_req_wdata = rd_data;
        if (mem_req_ready) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = REFILL_REQ;
        end
      end
      REFILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {addr_q.tag, idx, {(WORD_W+OFF_W){1'b0}}};
        if (mem_req_ready) begin
          beat_d  = '0;
          state_d = REFILL_WAIT;
        end
      end
      REFILL_WAIT: begin
        if (mem_resp_valid) begin
          arr_we    = 1'b1;
          arr_word  = beat_q;
          // A store miss lands its own word over the refilled one.
          arr_wdata = (we_q && beat_q == addr_q.word) ? wdata_q : mem_resp_rdata;
          beat_d    = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = RESPOND;
        end
      end
      RESPOND: begin
        cpu_resp_valid = 1'b1;
        cpu_resp_rdata = rd_data;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      way_q      <= '0;
      by_ptr_q   <= 1'b0;
      beat_q     <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      ptr_q      <= '0;
    end else begin
      state_q  <= state_d;
      way_q    <= way_d;
      by_ptr_q <= by_ptr_d;
      beat_q   <= beat_d;
      if (state_q == IDLE && cpu_req_valid) begin
        addr_q  <= split_addr(cpu_req_addr[31:OFF_W]);
        we_q    <= cpu_req_we;
        wdata_q <= cpu_req_wdata;
      end
      if (state_q == LOOKUP) begin
        if (hit) begin
          hit_cnt_q <= hit_cnt_q + 32'd1;
          if (we_q) dirty_q[idx][hit_way] <= 1'b1;
        end else begin
          miss_cnt_q <= miss_cnt_q + 32'd1;
          valid_q[idx][victim] <= 1'b0;
          dirty_q[idx][victim] <= 1'b0;
        end
      end
      if (refill_done) begin
        valid_q[idx][way_q] <= 1'b1;
        dirty_q[idx][way_q] <= we_q;
        if (by_ptr_q) ptr_q[idx] <= ptr_q[idx] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && refill_done) tag_q[idx][way_q] <= addr_q.tag;
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

  l1_data_array u_data (
    .clk     (clk),
    .we_i    (arr_we),
    .wset_i  (idx),
    .wway_i  (arr_way),
    .wword_i (arr_word),
    .wdata_i (arr_wdata),
    .rset_i  (idx),
    .rway_i  (way_q),
    .rword_i (rd_word),
    .rdata_o (rd_data)
  );

  a_req_stable: assert property (@(posedge clk) disable iff (rst)
    (cpu_req_valid && !cpu_req_ready) |=>
      (cpu_req_valid && $stable(cpu_req_addr) && $stable(cpu_req_we) && $stable(cpu_req_wdata)));
endmodule
